// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and constants for the PWM duty meter: FSM states, breath direction codes
// and the direction compare helper.
package pwm_duty_meter_pkg;

    localparam int unsigned CNT_W_DEF   = 18;
    localparam int unsigned TIMEOUT_DEF = 200_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_STATIC = 2'd3
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Direction of a new high width relative to the previous one; HOLD when there is no history.
    function automatic logic [1:0] breath_dir_of(input logic [31:0] cur,
                                                 input logic [31:0] prev,
                                                 input logic        known);
        if (!known || cur == prev) begin
            return DIR_HOLD;
        end
        return (cur > prev) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_edge_sync.sv
// Two-flop synchronizer plus delay flop; gives a clean level and single-cycle rise/fall strobes.
// Usable for any slow asynchronous input (keys, serial lines).
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic s2;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            dly <= 1'b0;
        end else begin
            s1  <= din;
            s2  <= s1;
            dly <= s2;
        end
    end

    assign level  = s2;
    assign rise_c = s2 & ~dly;
    assign fall_c = ~s2 & dly;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high width and period of a PWM line in clock cycles, reports the breath direction
// per completed period and flags a line that has stopped toggling.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] period,
    output logic             duty_valid,
    output logic [1:0]       breath_dir,
    output logic             stuck,
    output logic             stuck_level
);

    logic             level;
    logic             rise_c;
    logic             fall_c;
    logic             at_max_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hw_tmp;
    logic [CNT_W-1:0] prev_hw;
    logic             have_prev;
    state_t           state;

    edge_sync u_edge_sync (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .din    (pwm_in),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign at_max_c = (cnt >= TIMEOUT_MAX);

    // Cycles since the last detected rise; restarts at 1 on a rise and saturates at the timeout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= CNT_W'(1);
        end else if (!at_max_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Measurement FSM with registered results; a period is only reported when both of its rises were seen.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            hw_tmp      <= '0;
            prev_hw     <= '0;
            have_prev   <= 1'b0;
            high_width  <= '0;
            period      <= '0;
            duty_valid  <= 1'b0;
            breath_dir  <= DIR_HOLD;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise_c) begin
                        state <= ST_HIGH;
                    end else if (at_max_c) begin
                        state       <= ST_STATIC;
                        stuck       <= 1'b1;
                        stuck_level <= level;
                        have_prev   <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (fall_c) begin
                        state  <= ST_LOW;
                        hw_tmp <= cnt;
                    end else if (at_max_c) begin
                        state       <= ST_STATIC;
                        stuck       <= 1'b1;
                        stuck_level <= 1'b1;
                        have_prev   <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        state      <= ST_HIGH;
                        high_width <= hw_tmp;
                        period     <= cnt;
                        duty_valid <= 1'b1;
                        breath_dir <= breath_dir_of(32'(hw_tmp), 32'(prev_hw), have_prev);
                        prev_hw    <= hw_tmp;
                        have_prev  <= 1'b1;
                    end else if (at_max_c) begin
                        state       <= ST_STATIC;
                        stuck       <= 1'b1;
                        stuck_level <= 1'b0;
                        have_prev   <= 1'b0;
                    end
                end
                ST_STATIC: begin
                    if (rise_c) begin
                        state       <= ST_HIGH;
                        stuck       <= 1'b0;
                        stuck_level <= 1'b0;
                    end else begin
                        stuck_level <= level;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: 50 MHz clock, timeout shortened to 500 cycles,
// hand-computed widths, periods, directions and stuck behaviour.
module tb_pwm_duty_meter;

    localparam int unsigned CNT_W = 18;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             pwm_in;
    logic [CNT_W-1:0] high_width;
    logic [CNT_W-1:0] period;
    logic             duty_valid;
    logic [1:0]       breath_dir;
    logic             stuck;
    logic             stuck_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [CNT_W-1:0] q_hw[$];
    logic [CNT_W-1:0] q_per[$];
    logic [1:0]       q_dir[$];
    int               q_ts[$];

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_MAX (18'd500)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pwm_in      (pwm_in),
        .high_width  (high_width),
        .period      (period),
        .duty_valid  (duty_valid),
        .breath_dir  (breath_dir),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every cycle in which duty_valid is seen high
    always @(negedge sys_clk) begin
        if (duty_valid) begin
            q_hw.push_back(high_width);
            q_per.push_back(period);
            q_dir.push_back(breath_dir);
            q_ts.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int i, input logic [31:0] hw,
                             input logic [31:0] per, input logic [1:0] dir);
        if (q_hw.size() > i) begin
            chk({tag, "_hw"}, 32'(q_hw[i]), hw);
            chk({tag, "_per"}, 32'(q_per[i]), per);
            chk({tag, "_dir"}, 32'(q_dir[i]), 32'(dir));
        end else begin
            total++;
            bad++;
            $error("FAIL %s: pulse %0d missing, got %0d pulses expected more", tag, i, q_hw.size());
        end
    endtask

    task automatic clear_q();
        q_hw.delete();
        q_per.delete();
        q_dir.delete();
        q_ts.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hw"}, 32'(high_width), 0);
        chk({tag, "_per"}, 32'(period), 0);
        chk({tag, "_dv"}, 32'(duty_valid), 0);
        chk({tag, "_dir"}, 32'(breath_dir), 0);
        chk({tag, "_stuck"}, 32'(stuck), 0);
        chk({tag, "_slvl"}, 32'(stuck_level), 0);
    endtask

    task automatic reset_dut(input string tag);
        sys_rst_n = 1'b0;
        pwm_in    = 1'b0;
        #1;
        chk_zero(tag);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_q();
    endtask

    task automatic pwm_cycle(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge sys_clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge sys_clk);
    endtask

    task automatic close_period();
        pwm_in = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        pwm_in    = 1'b0;
        repeat (3) @(negedge sys_clk);

        // 1: steady 30/70; the first period after reset is only closed by the second rise
        reset_dut("rst1");
        pwm_cycle(30, 70);
        chk("t1_first_period_no_pulse", 32'(q_hw.size()), 0);
        repeat (3) pwm_cycle(30, 70);
        close_period();
        chk("t1_count", 32'(q_hw.size()), 4);
        for (int i = 0; i < 4; i++) chk_pulse("t1", i, 30, 100, 2'b00);

        // 2: rising then falling high widths
        reset_dut("rst2");
        pwm_cycle(10, 90);
        pwm_cycle(20, 80);
        pwm_cycle(30, 70);
        pwm_cycle(20, 80);
        close_period();
        chk("t2_count", 32'(q_hw.size()), 4);
        chk_pulse("t2_p0", 0, 10, 100, 2'b00);
        chk_pulse("t2_p1", 1, 20, 100, 2'b01);
        chk_pulse("t2_p2", 2, 30, 100, 2'b01);
        chk_pulse("t2_p3", 3, 20, 100, 2'b10);

        // 3: one-cycle high pulse, period 10
        reset_dut("rst3");
        repeat (5) pwm_cycle(1, 9);
        close_period();
        chk("t3_count", 32'(q_hw.size()), 5);
        for (int i = 0; i < 5; i++) chk_pulse("t3", i, 1, 10, 2'b00);
        if (q_ts.size() >= 5) begin
            for (int i = 1; i < 5; i++) chk("t3_spacing", 32'(q_ts[i] - q_ts[i-1]), 10);
        end

        // 4: line stuck high, then resumes 50/50
        reset_dut("rst4");
        pwm_in = 1'b1;
        repeat (495) @(negedge sys_clk);
        chk("t4_not_yet_stuck", 32'(stuck), 0);
        repeat (10) @(negedge sys_clk);
        chk("t4_stuck", 32'(stuck), 1);
        chk("t4_stuck_level", 32'(stuck_level), 1);
        repeat (95) @(negedge sys_clk);
        chk("t4_still_stuck", 32'(stuck), 1);
        chk("t4_no_pulse", 32'(q_hw.size()), 0);
        pwm_in = 1'b0;
        repeat (50) @(negedge sys_clk);
        chk("t4_stuck_until_rise", 32'(stuck), 1);
        pwm_in = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("t4_stuck_cleared", 32'(stuck), 0);
        chk("t4_no_pulse_first_rise", 32'(q_hw.size()), 0);
        repeat (45) @(negedge sys_clk);
        pwm_in = 1'b0;
        repeat (50) @(negedge sys_clk);
        pwm_cycle(50, 50);
        close_period();
        chk("t4_count", 32'(q_hw.size()), 2);
        chk_pulse("t4_p0", 0, 50, 100, 2'b00);
        chk_pulse("t4_p1", 1, 50, 100, 2'b00);

        // 5: line low from reset
        reset_dut("rst5");
        repeat (400) @(negedge sys_clk);
        chk("t5_not_yet_stuck", 32'(stuck), 0);
        repeat (200) @(negedge sys_clk);
        chk("t5_stuck", 32'(stuck), 1);
        chk("t5_stuck_level", 32'(stuck_level), 0);
        chk("t5_hw", 32'(high_width), 0);
        chk("t5_per", 32'(period), 0);
        chk("t5_dir", 32'(breath_dir), 0);
        chk("t5_no_pulse", 32'(q_hw.size()), 0);

        // 6: reset in the middle of a high phase
        reset_dut("rst6");
        pwm_cycle(30, 70);
        pwm_cycle(30, 70);
        pwm_in = 1'b1;
        repeat (10) @(negedge sys_clk);
        chk("t6_pre_hw", 32'(high_width), 30);
        sys_rst_n = 1'b0;
        #1;
        chk_zero("t6_midrst");
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_q();
        repeat (20) @(negedge sys_clk);
        pwm_in = 1'b0;
        repeat (70) @(negedge sys_clk);
        chk("t6_no_pulse_after_one_rise", 32'(q_hw.size()), 0);
        pwm_cycle(30, 70);
        close_period();
        chk("t6_count", 32'(q_hw.size()), 2);
        chk_pulse("t6_p0", 0, 20, 90, 2'b00);
        chk_pulse("t6_p1", 1, 30, 100, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
